// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_din,
  output logic                     gnt_active,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic [15:0]              wr_count
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N_REQ - 1);
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(MAX_BURST - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] gnt_nxt;
  logic [ID_W-1:0] rr_ptr, rr_nxt;
  logic [BC_W-1:0] beat_cnt, beat_nxt;
  logic [15:0]     wr_count_nxt;

  logic [ID_W-1:0] search_ptr;
  logic [ID_W-1:0] win_id;
  logic            win_found;
  logic            beat;
  logic            release_gnt;

  // Increment modulo N_REQ with an explicit compare so non-power-of-2 counts wrap correctly.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    return (v == LAST_ID) ? '0 : v + 1'b1;
  endfunction

  assign gnt_active = (state == S_GRANT);

  // While granted, the search starts just past the holder so the releasing requester is considered last.
  assign search_ptr = gnt_active ? wrap_inc(gnt_id) : rr_ptr;

  // Find the first valid requester at or above search_ptr, wrapping modulo N_REQ.
  always_comb begin : arb_search
    logic [ID_W-1:0] idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = search_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
      idx = wrap_inc(idx);
    end
  end

  // State register: grant, burst beat count, round-robin pointer and write counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      gnt_id   <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
      wr_count <= '0;
    end else begin
      state    <= state_nxt;
      gnt_id   <= gnt_nxt;
      beat_cnt <= beat_nxt;
      rr_ptr   <= rr_nxt;
      wr_count <= wr_count_nxt;
    end
  end

  // Output decode: only the granted requester sees ready, and nothing moves while the FIFO is full.
  always_comb begin
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    if (state == S_GRANT) begin
      req_ready[gnt_id] = ~fifo_full;
      fifo_wr_en        = req_valid[gnt_id] & ~fifo_full;
      fifo_din          = req_data[gnt_id*WIDTH +: WIDTH];
    end
  end

  assign beat = fifo_wr_en;

  // A burst ends on its last beat or when the holder drops valid; a full FIFO blocks the beat and so the burst end.
  assign release_gnt = (state == S_GRANT) &&
                       ((beat && (beat_cnt == LAST_BEAT)) || !req_valid[gnt_id]);

  // Next-state: grant from IDLE, count beats, and re-arbitrate on release without a bubble.
  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt_id;
    beat_nxt     = beat_cnt;
    rr_nxt       = rr_ptr;
    wr_count_nxt = (beat && (wr_count != 16'hFFFF)) ? wr_count + 16'd1 : wr_count;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          state_nxt = S_GRANT;
          gnt_nxt   = win_id;
          beat_nxt  = '0;
        end
      end
      S_GRANT: begin
        if (release_gnt) begin
          rr_nxt = search_ptr;
          if (win_found) begin
            gnt_nxt  = win_id;
            beat_nxt = '0;
          end else begin
            state_nxt = S_IDLE;
            beat_nxt  = '0;
          end
        end else if (beat) begin
          beat_nxt = beat_cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_din;
  logic           gnt_active;
  logic [1:0]     gnt_id;
  logic [15:0]    wr_count;

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .gnt_active (gnt_active),
    .gnt_id     (gnt_id),
    .wr_count   (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // producers: pending data per requester, and whether a beat is currently offered
  logic [W-1:0] pq [N][$];
  bit           holding [N];
  logic [W-1:0] drv [N];
  int           pct;
  int           full_mode;   // 0 never, 1 random, 2 depth-32 occupancy, 3 forced
  bit           full_force;
  int           occ;

  // reference model: who owns the port, beats left in the burst, next search start, writes
  bit           m_active;
  int           m_id;
  int           m_left;
  int           m_ptr;
  int           m_count;

  logic [W-1:0] exp_log [$];
  logic [W-1:0] dut_log [$];

  int passed;
  int total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int m_search(input int from, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!holding[i] && pq[i].size() > 0 && $urandom_range(99) < pct) holding[i] = 1'b1;
      drv[i] = holding[i] ? pq[i][0] : W'($urandom);
      req_valid[i] = holding[i];
      req_data[i*W +: W] = drv[i];
    end
    case (full_mode)
      1:       fifo_full = ($urandom_range(99) < 20);
      2:       fifo_full = (occ >= 32);
      3:       fifo_full = full_force;
      default: fifo_full = 1'b0;
    endcase
  endtask

  task automatic check_cycle();
    logic [N-1:0] er;
    logic         ew;
    logic [W-1:0] ed;
    er = '0;
    ew = 1'b0;
    ed = '0;
    if (m_active) begin
      er[m_id] = !fifo_full;
      ew       = req_valid[m_id] && !fifo_full;
      ed       = drv[m_id];
    end
    chk("req_ready", req_ready, er);
    chk("fifo_wr_en", fifo_wr_en, ew);
    chk("fifo_din", fifo_din, ed);
    chk("gnt_active", gnt_active, m_active);
    chk("wr_count", wr_count, m_count);
    chk("ready_onehot0", $onehot0(req_ready), 1);
    if (m_active) chk("gnt_id", gnt_id, m_id);
    if (fifo_wr_en === 1'b1) dut_log.push_back(fifo_din);
  endtask

  task automatic model_edge();
    logic [N-1:0] v;
    bit f, beat, rel;
    int w;
    v = req_valid;
    f = fifo_full;
    rel = 1'b0;
    beat = m_active && v[m_id] && !f;
    if (beat) begin
      if (m_count < 65535) m_count++;
      exp_log.push_back(pq[m_id].pop_front());
      holding[m_id] = 1'b0;
      occ++;
    end
    if (!m_active) begin
      w = m_search(m_ptr, v);
      if (w >= 0) begin
        m_active = 1'b1;
        m_id = w;
        m_left = MB;
      end
    end else if (!v[m_id]) begin
      rel = 1'b1;
    end else if (beat) begin
      m_left--;
      if (m_left == 0) rel = 1'b1;
    end
    if (rel) begin
      m_ptr = (m_id + 1) % N;
      w = m_search(m_ptr, v);
      if (w >= 0) begin
        m_id = w;
        m_left = MB;
      end else begin
        m_active = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    check_cycle();
    @(posedge clk);
    model_edge();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input bit midbeat);
    @(negedge clk);
    if (midbeat) begin
      drive();
      #1;
      chk("t6_midbeat_wr_en", fifo_wr_en, 1);
    end
    #2 rst = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_fifo_wr_en", fifo_wr_en, 0);
    chk("rst_fifo_din", fifo_din, 0);
    chk("rst_gnt_active", gnt_active, 0);
    chk("rst_wr_count", wr_count, 0);
    m_active = 1'b0;
    m_id = 0;
    m_left = 0;
    m_ptr = 0;
    m_count = 0;
    occ = 0;
    for (int i = 0; i < N; i++) holding[i] = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic cmp_logs(input string tag);
    chk({tag, "_count"}, dut_log.size(), exp_log.size());
    for (int k = 0; k < dut_log.size() && k < exp_log.size(); k++)
      chk({tag, "_data"}, dut_log[k], exp_log[k]);
    dut_log.delete();
    exp_log.delete();
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) pq[i].delete();
  endtask

  initial begin
    int budget;
    passed = 0;
    total = 0;
    pct = 100;
    full_mode = 0;
    full_force = 1'b0;
    occ = 0;
    req_valid = '0;
    req_data = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      holding[i] = 1'b0;
      drv[i] = '0;
    end
    rst = 1'b0;
    do_reset(1'b0);

    // 1: single requester, six beats across two bursts
    for (int k = 0; k < 6; k++) pq[1].push_back(8'h11 + 8'(k));
    run(14);
    chk("t1_count", dut_log.size(), 6);
    for (int k = 0; k < 6 && k < dut_log.size(); k++) chk("t1_const", dut_log[k], 8'h11 + k);
    chk("t1_wr_count", wr_count, 6);
    cmp_logs("t1");

    // 2: all four continuously valid, grants rotate 0,1,2,3,0 with four beats each
    do_reset(1'b0);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 12; k++) pq[i].push_back(8'(i * 32 + k));
    run(56);
    for (int n = 0; n < 20 && n < dut_log.size(); n++)
      chk("t2_rotation", dut_log[n], ((n / 4) % 4) * 32 + (n / 16) * 4 + n % 4);
    cmp_logs("t2");

    // 3: full stall after two beats of a req2 burst
    do_reset(1'b0);
    full_mode = 3;
    for (int k = 0; k < 8; k++) pq[2].push_back(8'hA0 + 8'(k));
    budget = 0;
    while (exp_log.size() < 2 && budget < 20) begin
      step();
      budget++;
    end
    chk("t3_timeout", exp_log.size() >= 2, 1);
    full_force = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t3_stall_gnt", gnt_id, 2);
    end
    full_force = 1'b0;
    run(14);
    cmp_logs("t3");

    // 4: req3 drops valid after one beat, req0 takes over from pointer 0
    pq[3].push_back(8'hD3);
    for (int k = 0; k < 3; k++) pq[0].push_back(8'hC0 + 8'(k));
    run(10);
    chk("t4_count", dut_log.size(), 4);
    if (dut_log.size() >= 2) begin
      chk("t4_first", dut_log[0], 8'hD3);
      chk("t4_second", dut_log[1], 8'hC0);
    end
    cmp_logs("t4");
    full_mode = 0;

    // 5: two requesters into a 32-deep FIFO that is never read
    do_reset(1'b0);
    full_mode = 2;
    for (int k = 0; k < 20; k++) begin
      pq[0].push_back(8'h40 + 8'(k));
      pq[1].push_back(8'h80 + 8'(k));
    end
    run(60);
    chk("t5_accepted", dut_log.size(), 32);
    chk("t5_wr_count", wr_count, 32);
    cmp_logs("t5");

    // 6: reset during a req1 beat
    full_mode = 0;
    do_reset(1'b0);
    clear_queues();
    for (int k = 0; k < 6; k++) pq[1].push_back(8'h60 + 8'(k));
    pq[3].push_back(8'hE0);
    pq[3].push_back(8'hE1);
    budget = 0;
    while (exp_log.size() < 1 && budget < 20) begin
      step();
      budget++;
    end
    chk("t6_timeout", exp_log.size() >= 1, 1);
    do_reset(1'b1);
    run(20);
    cmp_logs("t6");

    // randomized traffic with random full
    do_reset(1'b0);
    clear_queues();
    full_mode = 1;
    pct = 50;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 30; k++) pq[i].push_back(W'($urandom));
    run(300);
    cmp_logs("rand");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
